// File: rtl/pipe_skid_reg.sv
// Pipeline register with a one-entry skid buffer, flush/freeze control and a
// saturating backpressure counter.
module pipe_skid_reg #(
  parameter int DATA_W     = 158,
  parameter bit FLUSH_ZERO = 1'b1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              freeze,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] main_q;
  logic [DATA_W-1:0] skid_q;
  logic              acc;
  logic              drn;

  // in_ready is decoded from registered state and control only, never from
  // in_valid or out_ready, so no combinational path crosses the stage.
  assign in_ready  = !rst && !freeze && !flush && (state != TWO);
  assign acc       = in_valid && in_ready;
  assign out_valid = (state != EMPTY);
  assign drn       = out_valid && out_ready && !freeze;
  assign out_data  = main_q;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      EMPTY:   occupancy = 2'd0;
      ONE:     occupancy = 2'd1;
      TWO:     occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
      if (FLUSH_ZERO) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else if (!freeze) begin
      case (state)
        EMPTY: begin
          if (acc) begin
            main_q <= in_data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (acc && drn) begin
            main_q <= in_data;
          end else if (acc) begin
            skid_q <= in_data;
            state  <= TWO;
          end else if (drn) begin
            state <= EMPTY;
          end
        end
        TWO: begin
          // The older entry leaves; the skid entry becomes the new head.
          if (drn) begin
            main_q <= skid_q;
            state  <= ONE;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && !freeze && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Self-checking bench for pipe_skid_reg: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_pipe_skid_reg;

  localparam int DATA_W    = 32;
  localparam int CNT_W     = 4;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              flush = 1'b0;
  logic              freeze = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] in_data = '0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  int compared = 0;
  int mismatched = 0;
  bit checking = 1'b0;

  logic [DATA_W-1:0] model_q[$];
  logic [DATA_W-1:0] model_shadow = '0;
  int                model_stall = 0;

  pipe_skid_reg #(
    .DATA_W(DATA_W),
    .FLUSH_ZERO(1'b1),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .freeze(freeze),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .occupancy(occupancy),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int  n;
    bit  exp_ready;
    n = model_q.size();
    exp_ready = !rst && !flush && !freeze && (n < 2);
    check("in_ready", 64'(in_ready), 64'(exp_ready));
    check("out_valid", 64'(out_valid), 64'(n > 0));
    check("occupancy", 64'(occupancy), 64'(n));
    check("out_data", 64'(out_data), 64'((n > 0) ? model_q[0] : model_shadow));
    check("stall_cnt", 64'(stall_cnt), 64'(model_stall));
  endtask

  // Reference behaviour: a FIFO of at most two entries, updated once per edge.
  task automatic model_update();
    bit drained;
    bit accepted;
    if (rst) begin
      model_q.delete();
      model_shadow = '0;
      model_stall  = 0;
    end else if (flush) begin
      model_q.delete();
      model_shadow = '0;
    end else if (!freeze) begin
      drained  = (model_q.size() > 0) && out_ready;
      accepted = in_valid && (model_q.size() < 2);
      if ((model_q.size() > 0) && !out_ready && (model_stall < STALL_MAX))
        model_stall++;
      if (drained) void'(model_q.pop_front());
      if (accepted) model_q.push_back(in_data);
      if (model_q.size() > 0) model_shadow = model_q[0];
    end
  endtask

  task automatic apply_stimulus(input logic r, input logic f, input logic fz,
                                input logic iv, input logic [DATA_W-1:0] d,
                                input logic ordy);
    @(negedge clk);
    rst       = r;
    flush     = f;
    freeze    = fz;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    #1;
    if (checking) check_outputs();
    @(posedge clk);
    model_update();
  endtask

  initial begin
    $display("[TB] starting pipe_skid_reg bench");

    apply_stimulus(1, 0, 0, 0, '0, 0);
    checking = 1'b1;
    apply_stimulus(1, 0, 0, 1, 32'h77, 1);
    apply_stimulus(0, 0, 0, 0, '0, 0);
    check("reset_out_data", 64'(out_data), 64'h0);

    // Streaming with downstream always ready.
    apply_stimulus(0, 0, 0, 1, 32'h1, 1);
    apply_stimulus(0, 0, 0, 1, 32'h2, 1);
    apply_stimulus(0, 0, 0, 1, 32'h3, 1);
    apply_stimulus(0, 0, 0, 0, '0, 1);
    apply_stimulus(0, 0, 0, 0, '0, 1);

    // Skid fill, held-off third word, then drain in order.
    apply_stimulus(0, 0, 0, 1, 32'hA, 0);
    apply_stimulus(0, 0, 0, 1, 32'hB, 0);
    apply_stimulus(0, 0, 0, 1, 32'hC, 0);
    check("skid_full_ready", 64'(in_ready), 64'h0);
    apply_stimulus(0, 0, 0, 1, 32'hC, 1);
    apply_stimulus(0, 0, 0, 1, 32'hC, 1);
    apply_stimulus(0, 0, 0, 0, '0, 1);
    apply_stimulus(0, 0, 0, 0, '0, 1);

    // Flush from TWO while presenting 0xD.
    apply_stimulus(0, 0, 0, 1, 32'h11, 0);
    apply_stimulus(0, 0, 0, 1, 32'h12, 0);
    apply_stimulus(0, 1, 0, 1, 32'hD, 1);
    apply_stimulus(0, 0, 0, 0, '0, 1);
    check("flush_out_data", 64'(out_data), 64'h0);
    check("flush_occupancy", 64'(occupancy), 64'h0);

    // Freeze in ONE holding 0x5.
    apply_stimulus(0, 0, 0, 1, 32'h5, 0);
    for (int i = 0; i < 3; i++) apply_stimulus(0, 0, 1, 1, 32'h99, 1);
    apply_stimulus(0, 0, 0, 0, '0, 0);
    check("freeze_hold_data", 64'(out_data), 64'h5);

    // Flush wins over freeze.
    apply_stimulus(0, 1, 1, 1, 32'h42, 1);
    apply_stimulus(0, 0, 0, 0, '0, 0);
    check("flush_over_freeze", 64'(out_valid), 64'h0);

    // Stall counter saturation.
    apply_stimulus(0, 0, 0, 1, 32'h7, 0);
    for (int i = 0; i < 20; i++) apply_stimulus(0, 0, 0, 0, '0, 0);
    check("stall_saturate", 64'(stall_cnt), 64'(STALL_MAX));

    // Reset while in TWO.
    apply_stimulus(0, 0, 0, 1, 32'h21, 0);
    apply_stimulus(0, 0, 0, 1, 32'h22, 0);
    apply_stimulus(1, 0, 0, 1, 32'h23, 0);
    apply_stimulus(0, 0, 0, 0, '0, 0);
    check("reset_stall", 64'(stall_cnt), 64'h0);
    check("reset_data", 64'(out_data), 64'h0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus(($urandom_range(0, 63) == 0),
                     ($urandom_range(0, 15) == 0),
                     ($urandom_range(0, 7) == 0),
                     1'($urandom_range(0, 1)),
                     DATA_W'($urandom),
                     1'($urandom_range(0, 1)));
    end
    apply_stimulus(0, 0, 0, 0, '0, 1);
    apply_stimulus(0, 0, 0, 0, '0, 1);
    apply_stimulus(0, 0, 0, 0, '0, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

Interface
REQ-001 The module SHALL have parameter DATA_W, default 158, giving the width of the pipeline payload.
REQ-002 The module SHALL have parameter FLUSH_ZERO, default 1: 1 means flush zeroes stored payload, 0 means flush clears valid only.
REQ-003 The module SHALL have parameter CNT_W, default 16, giving the width of the stall counter.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port flush, input, 1 bit: discard all held entries, e.g. on branch taken.
REQ-007 The module SHALL have port freeze, input, 1 bit: hold all state, e.g. during an SRAM wait.
REQ-008 The module SHALL have port in_valid, input, 1 bit: upstream payload valid.
REQ-009 The module SHALL have port in_ready, output, 1 bit: the block can accept this cycle.
REQ-010 The module SHALL have port in_data, input, DATA_W bits: upstream payload.
REQ-011 The module SHALL have port out_valid, output, 1 bit: out_data holds a valid entry.
REQ-012 The module SHALL have port out_ready, input, 1 bit: downstream accepts this cycle.
REQ-013 The module SHALL have port out_data, output, DATA_W bits: the head entry, driven directly from the main register.
REQ-014 The module SHALL have port occupancy, output, 2 bits: number of held entries, 0 to 2.
REQ-015 The module SHALL have port stall_cnt, output, CNT_W bits: saturating count of backpressure cycles.

Function
REQ-016 Storage SHALL be a main register plus a skid register, tracked by states EMPTY (0 entries), ONE (main valid) and TWO (main and skid valid).
REQ-017 Qualifiers SHALL be: in_ready = !freeze & !flush & (state != TWO); acc = in_valid & in_ready; drn = out_valid & out_ready & !freeze.
REQ-018 Outputs SHALL be: out_valid = (state != EMPTY); occupancy is 0, 1 or 2 for EMPTY, ONE or TWO.
REQ-019 In EMPTY, acc SHALL load main with in_data and move to ONE, giving one cycle of latency from input to output.
REQ-020 In ONE, acc & drn SHALL load main with in_data and stay in ONE.
REQ-021 In ONE, acc & !drn SHALL load skid with in_data and move to TWO.
REQ-022 In ONE, !acc & drn SHALL move to EMPTY.
REQ-023 In TWO, drn SHALL copy skid into main and move to ONE; acc is impossible because in_ready = 0.
REQ-024 With no acc and no drn, state and data SHALL hold.
REQ-025 Order SHALL be preserved: entries leave in acceptance order, with none lost or duplicated.
REQ-026 Priority SHALL be rst > flush > freeze > normal operation.
REQ-027 flush SHALL move the state to EMPTY on the next edge; when FLUSH_ZERO=1, main and skid become 0.
REQ-028 Input presented during a flush cycle SHALL be dropped, with in_ready = 0 in that cycle.
REQ-029 A drain coinciding with flush SHALL be seen by downstream as consumed, but the entry is not retained.
REQ-030 freeze (without flush) SHALL hold state, main, skid and stall_cnt; in_ready = 0; out_valid keeps its value.
REQ-031 Downstream SHALL ignore out_ready during freeze, and no drain occurs.
REQ-032 stall_cnt SHALL increment by 1 on each edge where out_valid & !out_ready & !freeze & !flush, saturating at 2^CNT_W-1.
REQ-033 flush SHALL NOT clear stall_cnt.
REQ-034 When state is EMPTY, out_data SHALL be the last main value: 0 after reset or after a FLUSH_ZERO=1 flush.
REQ-035 Paths from in_valid to in_ready and from out_ready to in_ready SHALL be purely combinational-free; in_ready depends only on state, freeze and flush.

Reset
REQ-036 On rst=1 at a clock edge, the block SHALL set state to EMPTY, main=0, skid=0 and stall_cnt=0.
REQ-037 After that reset edge, outputs SHALL read out_valid=0, occupancy=0 and out_data=0.
REQ-038 rst asserted mid-operation (in ONE or TWO, frozen or not) SHALL discard all entries at that edge.
REQ-039 In cycles where rst=1, in_ready SHALL be 0.

Verification
REQ-040 Streaming: with out_ready=1, push 0x1,0x2,0x3 on consecutive cycles -> out_data shows 0x1,0x2,0x3 on cycles 1-3, occupancy stays 1, stall_cnt=0.
REQ-041 Skid fill: out_ready=0, push 0xA then 0xB -> occupancy=2 and in_ready=0; push 0xC is held off; then out_ready=1 -> output order 0xA,0xB,0xC.
REQ-042 Flush: in state TWO, assert flush while presenting 0xD -> next cycle occupancy=0, out_valid=0, out_data=0, 0xD is never output.
REQ-043 Freeze: in state ONE holding 0x5, freeze=1 for 3 cycles with out_ready=1 and in_valid=1 -> out_data stays 0x5, stall_cnt is unchanged, nothing is accepted.
REQ-044 Flush over freeze: freeze=1 and flush=1 together in state ONE -> state EMPTY on the next edge.
REQ-045 Saturation: with CNT_W=4, out_valid=1 and out_ready=0 for 20 cycles -> stall_cnt = 15.
REQ-046 Reset: rst=1 for 1 cycle while in state TWO -> occupancy=0, stall_cnt=0, out_data=0.
